// File: rtl/pdp8l_iop_seq_pkg.sv
// Shared constants, FSM encodings and pulse-selection helpers for the PDP-8/L IOP sequencer.
package pdp8l_iop_seq_pkg;

    localparam int FILTER_DEF = 3;
    localparam int MAXLEN_DEF = 2000;
    localparam int CNTW_DEF   = 16;

    localparam int IOP1 = 0;
    localparam int IOP2 = 1;
    localparam int IOP4 = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_QUAL    = 3'd1;
    localparam state_t ST_ACTIVE  = 3'd2;
    localparam state_t ST_DEQUAL  = 3'd3;
    localparam state_t ST_WAITREL = 3'd4;

    // IOP1 wins over IOP2 wins over IOP4 when several lines are low together.
    function automatic logic [2:0] lowest_one(input logic [2:0] set);
        return set & (~set + 3'd1);
    endfunction

    function automatic logic multi_hot(input logic [2:0] set);
        return (set & (set - 3'd1)) != 3'd0;
    endfunction

endpackage

// File: rtl/pdp8l_iop_seq_if.sv
// IOT-side bus of the sequencer: raw PDP-8/L inputs, control inputs and clean fabric outputs.
interface pdp8l_iop_seq_if #(
    parameter int CNTW = 16
);
    logic            _iop1;
    logic            _iop2;
    logic            _iop4;
    logic [11:0]     mbin;
    logic            enable;
    logic            nanocycle;
    logic            nanostep;
    logic            errclr;
    logic            iopstart;
    logic            iopstop;
    logic [11:0]     ioopcode;
    logic            ioperr;
    logic [CNTW-1:0] iopcount;

    modport master (
        output _iop1, _iop2, _iop4, mbin, enable, nanocycle, nanostep, errclr,
        input  iopstart, iopstop, ioopcode, ioperr, iopcount
    );

    modport slave (
        input  _iop1, _iop2, _iop4, mbin, enable, nanocycle, nanostep, errclr,
        output iopstart, iopstop, ioopcode, ioperr, iopcount
    );
endinterface

// File: rtl/pdp8l_iop_seq_sync_filter.sv
// Two-flop synchronizer for one active-low IOP line plus a step-gated level filter.
module pdp8l_iop_seq_sync_filter #(
    parameter int FILTER = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw_n,
    input  logic i_step,
    output logic o_act,
    output logic o_filt
);
    localparam int FW = $clog2(FILTER + 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_filt;
    logic [FW-1:0] r_cnt;

    // Sync runs every clock; the filter only accepts a new level after FILTER steps of agreement.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_s1 <= ~i_raw_n;
            r_s2 <= r_s1;
            if (i_step) begin
                if (r_s2 == r_filt) begin
                    r_cnt <= '0;
                end else if (r_cnt == FW'(FILTER - 1)) begin
                    r_filt <= r_s2;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + FW'(1);
                end
            end
        end
    end

    assign o_act  = r_s2;
    assign o_filt = r_filt;

endmodule

// File: rtl/pdp8l_iop_seq.sv
// PDP-8/L IOT front end: qualifies raw IOP pulses into one-cycle iopstart/iopstop with a
// stable latched opcode, flags malformed pulse trains and counts accepted IOTs.
module pdp8l_iop_seq
    import pdp8l_iop_seq_pkg::*;
#(
    parameter int FILTER = FILTER_DEF,
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int CNTW   = CNTW_DEF
) (
    input  logic            CLOCK,
    input  logic            RESET,
    pdp8l_iop_seq_if.slave  io_bus
);
    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(MAXLEN + 1);

    logic [2:0]      w_act;
    logic [2:0]      w_filt;
    logic [2:0]      w_pick;
    logic            w_step;
    logic            w_err;
    logic [11:0]     r_mb1;
    logic [11:0]     r_mb2;
    logic            r_lastnanostep;
    state_t          r_state;
    logic [2:0]      r_qset;
    logic [2:0]      r_sel;
    logic [FW-1:0]   r_fcnt;
    logic [TW-1:0]   r_tmo;
    logic            r_iopstart;
    logic            r_iopstop;
    logic [11:0]     r_ioopcode;
    logic            r_ioperr;
    logic [CNTW-1:0] r_iopcount;

    pdp8l_iop_seq_sync_filter #(.FILTER(FILTER)) u_iop1 (
        .i_clk(CLOCK), .i_rst(RESET), .i_raw_n(io_bus._iop1), .i_step(w_step),
        .o_act(w_act[IOP1]), .o_filt(w_filt[IOP1])
    );
    pdp8l_iop_seq_sync_filter #(.FILTER(FILTER)) u_iop2 (
        .i_clk(CLOCK), .i_rst(RESET), .i_raw_n(io_bus._iop2), .i_step(w_step),
        .o_act(w_act[IOP2]), .o_filt(w_filt[IOP2])
    );
    pdp8l_iop_seq_sync_filter #(.FILTER(FILTER)) u_iop4 (
        .i_clk(CLOCK), .i_rst(RESET), .i_raw_n(io_bus._iop4), .i_step(w_step),
        .o_act(w_act[IOP4]), .o_filt(w_filt[IOP4])
    );

    assign w_step = !io_bus.nanocycle || (io_bus.nanostep && !r_lastnanostep);
    assign w_pick = lowest_one(w_act);

    // MB synchronizer and nanostep edge history, both free-running.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_mb1          <= 12'o0000;
            r_mb2          <= 12'o0000;
            r_lastnanostep <= 1'b0;
        end else begin
            r_mb1          <= io_bus.mbin;
            r_mb2          <= r_mb1;
            r_lastnanostep <= io_bus.nanostep;
        end
    end

    // Error sources: ambiguous acceptance, foreign pulse while active, stuck pulse.
    always_comb begin
        w_err = 1'b0;
        if (io_bus.enable && w_step) begin
            case (r_state)
                ST_QUAL:   w_err = (w_act == r_qset) && (r_fcnt == FW'(FILTER - 1)) && multi_hot(w_act);
                ST_ACTIVE: w_err = ((w_act & ~r_sel) != 3'b000) ||
                                   (((w_act & r_sel) != 3'b000) && (r_tmo == TW'(MAXLEN - 1)));
                default:   w_err = 1'b0;
            endcase
        end else begin
            w_err = 1'b0;
        end
    end

    // Main sequencer; a disabled block abandons the IOT and waits for the lines to clear.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_qset     <= 3'b000;
            r_sel      <= 3'b000;
            r_fcnt     <= '0;
            r_tmo      <= '0;
            r_iopstart <= 1'b0;
            r_iopstop  <= 1'b0;
            r_ioopcode <= 12'o0000;
            r_iopcount <= '0;
        end else begin
            r_iopstart <= 1'b0;
            r_iopstop  <= 1'b0;
            if (!io_bus.enable) begin
                r_ioopcode <= 12'o0000;
                // Only an IOT that announced a start is owed a stop.
                if (r_state == ST_ACTIVE || r_state == ST_DEQUAL) begin
                    r_iopstop <= 1'b1;
                end
                if (r_state == ST_WAITREL) begin
                    if (w_step && w_filt == 3'b000) begin
                        r_state <= ST_IDLE;
                    end
                end else if (r_state != ST_IDLE) begin
                    r_state <= ST_WAITREL;
                end
            end else if (w_step) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_act != 3'b000) begin
                            r_state <= ST_QUAL;
                            r_qset  <= w_act;
                            r_fcnt  <= '0;
                        end
                    end
                    ST_QUAL: begin
                        if (w_act == 3'b000) begin
                            r_state <= ST_IDLE;
                        end else if (w_act != r_qset) begin
                            r_qset <= w_act;
                            r_fcnt <= '0;
                        end else if (r_fcnt == FW'(FILTER - 1)) begin
                            r_sel      <= w_pick;
                            r_ioopcode <= {r_mb2[11:3], r_mb2[2:0] & w_pick};
                            r_iopstart <= 1'b1;
                            r_iopcount <= r_iopcount + CNTW'(1);
                            r_tmo      <= '0;
                            r_state    <= ST_ACTIVE;
                        end else begin
                            r_fcnt <= r_fcnt + FW'(1);
                        end
                    end
                    ST_ACTIVE: begin
                        if ((w_act & r_sel) == 3'b000) begin
                            r_state <= ST_DEQUAL;
                            r_fcnt  <= '0;
                        end else if (r_tmo == TW'(MAXLEN - 1)) begin
                            r_iopstop <= 1'b1;
                            r_state   <= ST_WAITREL;
                        end else begin
                            r_tmo <= r_tmo + TW'(1);
                        end
                    end
                    ST_DEQUAL: begin
                        if ((w_act & r_sel) != 3'b000) begin
                            r_state <= ST_ACTIVE;
                        end else if (r_fcnt == FW'(FILTER - 1)) begin
                            r_iopstop <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_fcnt <= r_fcnt + FW'(1);
                        end
                    end
                    ST_WAITREL: begin
                        if (w_filt == 3'b000) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Sticky error; a fresh error outranks a simultaneous clear.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_ioperr <= 1'b0;
        end else if (w_err) begin
            r_ioperr <= 1'b1;
        end else if (io_bus.errclr) begin
            r_ioperr <= 1'b0;
        end
    end

    assign io_bus.iopstart = r_iopstart;
    assign io_bus.iopstop  = r_iopstop;
    assign io_bus.ioopcode = r_ioopcode;
    assign io_bus.ioperr   = r_ioperr;
    assign io_bus.iopcount = r_iopcount;

endmodule

// File: doc/pdp8l_iop_seq.md
Name: pdp8l_iop_seq

Overview:
- Front end for PDP-8/L IOT traffic; sits directly upstream of the extended-memory controller and other IOT-decoding devices.
- Synchronizes and glitch-filters the raw, asynchronous, active-low IOP1/IOP2/IOP4 pulses and the buffered MB.
- Produces, in the fabric clock domain, a clean one-cycle iopstart, a one-cycle iopstop, and a stable 12-bit ioopcode.
- Flags malformed pulse trains and counts IOTs for the arm side.

Parameters:
FILTER, 3, consecutive clocks a synchronized level must hold before being accepted (applies to assert and deassert)
MAXLEN, 2000, max clocks an IOP pulse may stay active before it is declared stuck
CNTW, 16, width of the IOT event counter

Ports:
CLOCK  in  1  fabric clock, 100 MHz
RESET  in  1  synchronous, active-high reset
_iop1  in  1  raw IOP1 from PDP-8/L, active low, asynchronous
_iop2  in  1  raw IOP2, active low, asynchronous
_iop4  in  1  raw IOP4, active low, asynchronous
mbin  in  12  raw buffered MB (IOT instruction), asynchronous
enable  in  1  0 = block idle, outputs held at reset values
nanocycle  in  1  0 = normal; 1 = advance only on nanostep rising edge
nanostep  in  1  debug step clock, sampled on CLOCK
iopstart  out  1  one-cycle pulse, accepted IOP leading edge
iopstop  out  1  one-cycle pulse, accepted IOP trailing edge or timeout
ioopcode  out  12  [11:3] = MB[11:3]; [2:0] = one-hot active pulse AND MB[2:0]
ioperr  out  1  sticky error flag
iopcount  out  CNTW  accepted iopstart count, wraps modulo 2^CNTW
errclr  in  1  one-cycle pulse, clears ioperr

Behaviour:
- Reset: iopstart=0, iopstop=0, ioopcode=0, ioperr=0, iopcount=0, state=IDLE, synchronizers=inactive, filter counter=0, lastnanostep=0.
- Synchronizers:
  - Each of _iop1/_iop2/_iop4 and all mbin bits pass through a 2-flop synchronizer.
  - The synchronizers run every CLOCK regardless of nanocycle.
- Step gating: when nanocycle=1, the FSM, filter counters, timeout and counter advance only in the cycle where nanostep is first seen high (tracked via lastnanostep). iopstart/iopstop still last exactly one CLOCK.
- FSM states: IDLE, QUAL, ACTIVE, DEQUAL, WAITREL.
  - IDLE: on any synchronized pulse low, go to QUAL with the filter count cleared. If enable=0, stay in IDLE.
  - QUAL:
    - The same pulse set must stay low for FILTER steps.
    - If the set changes to a nonempty different set, restart the count.
    - If the set goes empty, return to IDLE without output (glitch rejected).
    - On acceptance:
      - Latch ioopcode from the synchronized MB, with bits [2:0] masked to the accepted pulse.
      - Assert iopstart for 1 cycle and increment iopcount.
      - Enter ACTIVE.
    - If more than one pulse is low at acceptance, set ioperr and select the lowest-numbered pulse (IOP1 > IOP2 > IOP4).
  - ACTIVE:
    - ioopcode is held stable.
    - If a different pulse goes low, set ioperr and ignore it.
    - When the accepted pulse goes high, enter DEQUAL.
    - If ACTIVE lasts MAXLEN steps, set ioperr, assert iopstop, and enter WAITREL.
  - DEQUAL:
    - The pulse must stay high FILTER steps; then assert iopstop for 1 cycle and go to IDLE.
    - If it returns low first, go back to ACTIVE with the timeout not reset.
  - WAITREL: wait until all three pulses are high for FILTER steps, then go to IDLE. No iopstart is issued in this state.
- ioopcode: holds its value after iopstop until the next acceptance. Downstream devices qualify it with iopstart only.
- Latency: raw edge to iopstart = 2 sync + FILTER + 1 clocks (6 at defaults). Trailing-edge latency is the same to iopstop.
- enable dropping mid-operation: if not IDLE, emit iopstop at once (unless one was already issued), then go to WAITREL. While enable=0, outputs other than iopcount/ioperr are forced to 0.
- errclr: clears ioperr. If errclr coincides with a new error in the same cycle, the error wins.
- RESET mid-pulse: the block goes to IDLE. A pulse still held low after reset is treated as new, so QUAL runs and one iopstart is issued.

Decomposition:
- Shared package pdp8l_pkg:
  - FSM state enum.
  - IOP bit indices IOP1=0, IOP2=1, IOP4=2.
  - Default FILTER/MAXLEN constants.
- Sub-module sync_filter: 2-flop sync plus FILTER-step level filter, with a step-enable input. Instantiate it once per pulse line; mbin uses plain 2-flop sync.

Test Plan:
- Clean 6214 with IOP4 low 50 clocks, mbin=o6214 -> iopstart at clock 6; ioopcode=o6214; iopstop 6 clocks after release; iopcount=1; ioperr=0.
- IOP1 glitch 2 clocks wide -> no iopstart, no iopstop, iopcount unchanged.
- mbin=o6203 with IOP1 then IOP2 sequential pulses -> two iopstarts, ioopcode o6201 then o6202, iopcount=2.
- IOP2 held low 2100 clocks -> ioperr=1 and iopstop at MAXLEN; no new iopstart until released for 3 clocks; errclr -> ioperr=0.
- IOP1 and IOP4 asserted together, mbin=o6205 -> ioopcode=o6201, ioperr=1.
- nanocycle=1, IOP4 held low, one nanostep per 20 clocks -> iopstart after 4 steps, still 1 clock wide. Then RESET mid-ACTIVE -> outputs 0, followed by a fresh iopstart.
